// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives datapath enables, mux selects and the 3-bit ALUOp to the ALU decoder.
module mc_main_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Func,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_RTYP = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_LUI  = 3'b101;
  localparam logic [2:0] ALU_ADD  = 3'b110;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_EXE_R   = 4'd7,
    S_R_WB    = 4'd8,
    S_EXE_I   = 4'd9,
    S_I_WB    = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_JAL     = 4'd13,
    S_JR      = 4'd14
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   ready;
  logic   r_func_ok;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // JR is handled separately; these are the R-type ops that write rd.
  always_comb begin
    unique case (Func)
      FN_SLL, FN_ADDU, FN_SUBU, FN_OR, FN_SLT: r_func_ok = 1'b1;
      default:                                 r_func_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RST;
    else     state <= state_nxt;
  end

  always_comb begin
    ctrl      = '0;
    state_nxt = S_FETCH;
    case (state)
      S_RST: state_nxt = S_FETCH;

      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        // PC+4 and IR commit only on the cycle memory delivers the word
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
        state_nxt      = ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
        case (Opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADR;
          OP_RTYPE: begin
            if (Func == FN_JR)  state_nxt = S_JR;
            else if (r_func_ok) state_nxt = S_EXE_R;
            else begin
              ctrl.illegal = 1'b1;
              state_nxt    = S_FETCH;
            end
          end
          OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: state_nxt = S_EXE_I;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:           state_nxt = S_JUMP;
          OP_JAL:         state_nxt = S_JAL;
          default: begin
            ctrl.illegal = 1'b1;
            state_nxt    = S_FETCH;
          end
        endcase
      end

      S_MEM_ADR: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
        state_nxt      = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        state_nxt     = ready ? S_MEM_WB : S_MEM_RD;
      end

      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b00;
        ctrl.mem_to_reg = 2'b01;
        state_nxt       = S_FETCH;
      end

      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        state_nxt      = ready ? S_FETCH : S_MEM_WR;
      end

      S_EXE_R: begin
        ctrl.alu_src_a = (Func == FN_SLL) ? 2'b10 : 2'b01;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALU_RTYP;
        state_nxt      = S_R_WB;
      end

      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b01;
        ctrl.mem_to_reg = 2'b00;
        state_nxt       = S_FETCH;
      end

      S_EXE_I: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        case (Opcode)
          OP_SLTI:  ctrl.alu_op = ALU_SLT;
          OP_SLTIU: ctrl.alu_op = ALU_SLTU;
          OP_LUI:   ctrl.alu_op = ALU_LUI;
          default:  ctrl.alu_op = ALU_ADD;
        endcase
        state_nxt = S_I_WB;
      end

      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b00;
        ctrl.mem_to_reg = 2'b00;
        state_nxt       = S_FETCH;
      end

      S_BRANCH: begin
        ctrl.alu_src_a     = 2'b01;
        ctrl.alu_src_b     = 2'b00;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.branch_ne     = (Opcode == OP_BNE);
        state_nxt          = S_FETCH;
      end

      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        state_nxt      = S_FETCH;
      end

      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b11;
        state_nxt      = S_FETCH;
      end

      // link value is the already-incremented PC
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b10;
        ctrl.mem_to_reg = 2'b10;
        state_nxt       = S_FETCH;
      end

      default: begin
        ctrl.alu_op = ALU_NONE;
        state_nxt   = S_FETCH;
      end
    endcase
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign BranchNE    = ctrl.branch_ne;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign illegal     = ctrl.illegal;

endmodule
